image_loader: RTL and testbench

// Writer side of the image memory that the network's image reader consumes. Accepts a byte stream from the host,

---
 rtl/image_loader.sv | 117 +++++++++++
 tb/tb_image_loader.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/image_loader.sv
// Host-side image writer: packs byte pairs into 16-bit pixels, fills image memory,
// launches one inference and returns the category (or -1 on timeout) to the host.
module image_loader #(
  parameter int unsigned IMG_WORDS   = 784,
  parameter int unsigned ADDR_W      = 16,
  parameter int unsigned TIMEOUT_CYC = 65535
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [7:0]          in_byte,
  input  logic                in_valid,
  output logic                in_ready,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [15:0]         mem_data,
  output logic                mem_we,
  output logic                start_net,
  input  logic                one_end,
  input  logic signed [3:0]   categories,
  output logic signed [3:0]   result,
  output logic                result_valid,
  output logic                timeout,
  output logic [15:0]         img_count
);

  localparam int unsigned        TCNT_W    = $clog2(TIMEOUT_CYC + 1);
  localparam logic [ADDR_W-1:0]  LAST_ADDR = ADDR_W'(IMG_WORDS - 1);
  localparam logic [TCNT_W-1:0]  TCNT_LAST = TCNT_W'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {LOAD, WRITE, START, RUN} state_t;

  state_t             state;
  logic               phase_high;
  logic [7:0]         low_byte;
  logic [ADDR_W-1:0]  ptr;
  logic [TCNT_W-1:0]  tcnt;
  logic [TCNT_W-1:0]  tcnt_inc;

  assign tcnt_inc = tcnt + TCNT_W'(1);

  // Single FSM; every output is a register. Strobes default low each cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= LOAD;
      phase_high   <= 1'b0;
      low_byte     <= 8'd0;
      ptr          <= '0;
      tcnt         <= '0;
      in_ready     <= 1'b0;
      mem_addr     <= '0;
      mem_data     <= 16'd0;
      mem_we       <= 1'b0;
      start_net    <= 1'b0;
      result       <= 4'sd0;
      result_valid <= 1'b0;
      timeout      <= 1'b0;
      img_count    <= 16'd0;
    end else begin
      mem_we       <= 1'b0;
      start_net    <= 1'b0;
      result_valid <= 1'b0;
      case (state)
        LOAD: begin
          in_ready <= 1'b1;
          if (in_valid && in_ready) begin
            if (!phase_high) begin
              low_byte   <= in_byte;
              phase_high <= 1'b1;
            end else begin
              mem_data   <= {in_byte, low_byte};
              mem_addr   <= ptr;
              phase_high <= 1'b0;
              in_ready   <= 1'b0;
              mem_we     <= 1'b1;
              state      <= WRITE;
            end
          end
        end
        WRITE: begin
          if (ptr == LAST_ADDR) begin
            ptr       <= '0;
            start_net <= 1'b1;
            state     <= START;
          end else begin
            ptr      <= ptr + ADDR_W'(1);
            in_ready <= 1'b1;
            state    <= LOAD;
          end
        end
        START: begin
          timeout <= 1'b0;
          tcnt    <= '0;
          state   <= RUN;
        end
        RUN: begin
          tcnt <= tcnt_inc;
          // A completion in the expiry cycle takes precedence over the abort.
          if (one_end) begin
            result       <= categories;
            result_valid <= 1'b1;
            img_count    <= img_count + 16'd1;
            in_ready     <= 1'b1;
            state        <= LOAD;
          end else if (tcnt_inc == TCNT_LAST) begin
            result       <= -4'sd1;
            timeout      <= 1'b1;
            result_valid <= 1'b1;
            img_count    <= img_count + 16'd1;
            in_ready     <= 1'b1;
            state        <= LOAD;
          end
        end
        default: state <= LOAD;
      endcase
    end
  end

endmodule

// File: tb/tb_image_loader.sv
// Scoreboard bench for image_loader: stimulus queues expected writes/results,
// a negedge monitor pops and compares whenever the DUT strobes an output.
module tb_image_loader;

  localparam int unsigned IMG_WORDS   = 784;
  localparam int unsigned ADDR_W      = 16;
  localparam int unsigned TIMEOUT_CYC = 16;

  logic                clk = 1'b0;
  logic                reset;
  logic [7:0]          in_byte;
  logic                in_valid;
  logic                in_ready;
  logic [ADDR_W-1:0]   mem_addr;
  logic [15:0]         mem_data;
  logic                mem_we;
  logic                start_net;
  logic                one_end;
  logic signed [3:0]   categories;
  logic signed [3:0]   result;
  logic                result_valid;
  logic                timeout;
  logic [15:0]         img_count;

  image_loader #(
    .IMG_WORDS  (IMG_WORDS),
    .ADDR_W     (ADDR_W),
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .in_byte     (in_byte),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .mem_addr    (mem_addr),
    .mem_data    (mem_data),
    .mem_we      (mem_we),
    .start_net   (start_net),
    .one_end     (one_end),
    .categories  (categories),
    .result      (result),
    .result_valid(result_valid),
    .timeout     (timeout),
    .img_count   (img_count)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [15:0] addr;
    logic [15:0] data;
  } wr_t;

  typedef struct {
    logic signed [3:0] res;
    logic              to;
    logic [15:0]       cnt;
    int unsigned       lat;
  } rs_t;

  wr_t wq[$];
  rs_t rq[$];
  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    n_vec++;
    n_err++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  // Pixel 0 is 16'h1234, sent as 0x34 then 0x12.
  function automatic logic [15:0] pix(input int unsigned i);
    return 16'(i * 40503) ^ 16'h1234;
  endfunction

  // Monitor
  bit          gapfree = 1'b0;
  bit          seen_we = 1'b0;
  int unsigned last_we_cyc = 0;
  int unsigned start_cyc = 0;
  logic [15:0] last_we_addr = 16'd0;
  wr_t         w;
  rs_t         r;

  always @(negedge clk) begin
    if (!reset) begin
      if (mem_we) begin
        if (wq.size() == 0) fail_now("unexpected mem_we");
        else begin
          w = wq.pop_front();
          chk("mem_addr", 32'(mem_addr), 32'(w.addr));
          chk("mem_data", 32'(mem_data), 32'(w.data));
        end
        if (gapfree && seen_we && mem_addr != 16'd0)
          chk("we_spacing", cyc - last_we_cyc, 32'd3);
        last_we_cyc  = cyc;
        last_we_addr = mem_addr;
        seen_we      = 1'b1;
      end
      if (start_net) begin
        chk("start_after_we", cyc - last_we_cyc, 32'd1);
        chk("start_last_addr", 32'(last_we_addr), 32'(IMG_WORDS - 1));
        start_cyc = cyc;
      end
      if (result_valid) begin
        if (rq.size() == 0) fail_now("unexpected result_valid");
        else begin
          r = rq.pop_front();
          chk("result", 32'(result), 32'(r.res));
          chk("timeout", 32'(timeout), 32'(r.to));
          chk("img_count", 32'(img_count), 32'(r.cnt));
          chk("ready_at_result", 32'(in_ready), 32'd1);
          chk("result_latency", cyc - start_cyc, r.lat);
        end
      end
    end
  end

  // Stimulus
  task automatic send_byte(input logic [7:0] b, input bit gaps);
    int unsigned n = 0;
    forever begin
      @(negedge clk);
      if (gaps && $urandom_range(1, 0) == 0) begin
        in_valid = 1'b0;
      end else begin
        in_valid = 1'b1;
        in_byte  = b;
        if (in_ready) break;
      end
      n++;
      if (n > 200) begin
        fail_now("in_ready never rose");
        break;
      end
    end
  endtask

  task automatic send_pixels(input int unsigned n, input bit gaps);
    logic [15:0] p;
    for (int unsigned i = 0; i < n; i++) begin
      p = pix(i);
      send_byte(p[7:0], gaps);
      wq.push_back('{addr: 16'(i), data: p});
      send_byte(p[15:8], gaps);
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic run_image(input bit gaps, input int unsigned run_n,
                           input logic signed [3:0] cat, input logic signed [3:0] exp_res,
                           input logic exp_to, input logic [15:0] exp_cnt,
                           input int unsigned exp_lat, input logic prev_to);
    bit got = 1'b0;
    gapfree = gaps ? 1'b0 : 1'b1;
    chk("timeout_before_load", 32'(timeout), 32'(prev_to));
    // A completion strobe while loading must be ignored.
    @(negedge clk);
    one_end    = 1'b1;
    categories = 4'sd2;
    @(negedge clk);
    one_end = 1'b0;
    send_pixels(IMG_WORDS, gaps);
    for (int k = 0; k < 20; k++) begin
      if (start_net) begin
        got = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!got) fail_now("start_net missing");
    rq.push_back('{res: exp_res, to: exp_to, cnt: exp_cnt, lat: exp_lat});
    for (int unsigned k = 1; k <= ((run_n > 0) ? run_n : 1); k++) begin
      @(negedge clk);
      if (k == 1) chk("timeout_cleared", 32'(timeout), 32'd0);
    end
    if (run_n > 0) begin
      one_end    = 1'b1;
      categories = cat;
      @(negedge clk);
      one_end = 1'b0;
    end
    repeat (TIMEOUT_CYC + 4) @(negedge clk);
    chk("result_pending", rq.size(), 32'd0);
    chk("hold_addr", 32'(mem_addr), 32'(IMG_WORDS - 1));
    chk("hold_data", 32'(mem_data), 32'(pix(IMG_WORDS - 1)));
    chk("ready_idle", 32'(in_ready), 32'd1);
  endtask

  task automatic check_reset_vals();
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    chk("rst_start_net", 32'(start_net), 32'd0);
    chk("rst_result", 32'(result), 32'd0);
    chk("rst_result_valid", 32'(result_valid), 32'd0);
    chk("rst_timeout", 32'(timeout), 32'd0);
    chk("rst_img_count", 32'(img_count), 32'd0);
    chk("rst_mem_addr", 32'(mem_addr), 32'd0);
    chk("rst_mem_data", 32'(mem_data), 32'd0);
  endtask

  initial begin
    reset      = 1'b1;
    in_valid   = 1'b0;
    in_byte    = 8'd0;
    one_end    = 1'b0;
    categories = 4'sd0;
    repeat (3) @(negedge clk);
    check_reset_vals();
    reset = 1'b0;
    @(negedge clk);
    chk("ready_after_reset", 32'(in_ready), 32'd1);

    // Gap-free load, category 7 on the 10th RUN cycle.
    run_image(1'b0, 10, 4'sd7, 4'sd7, 1'b0, 16'd1, 11, 1'b0);
    // Random gaps, no completion: abort with -1.
    run_image(1'b1, 0, 4'sd0, -4'sd1, 1'b1, 16'd2, TIMEOUT_CYC, 1'b0);
    // Completion on the expiry cycle wins.
    run_image(1'b0, TIMEOUT_CYC - 1, -4'sd3, -4'sd3, 1'b0, 16'd3, TIMEOUT_CYC, 1'b1);

    // Reset after 300 pixels plus a dangling low byte.
    gapfree = 1'b1;
    send_pixels(300, 1'b0);
    send_byte(8'hEE, 1'b0);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("writes_drained", wq.size(), 32'd0);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    check_reset_vals();
    reset = 1'b0;
    @(negedge clk);
    chk("ready_after_midreset", 32'(in_ready), 32'd1);
    run_image(1'b0, 3, 4'sd5, 4'sd5, 1'b0, 16'd1, 4, 1'b0);

    chk("writes_left", wq.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
